// File: rtl/ieee_fp_pkg.sv
// Shared IEEE-754 single-precision constants and sequencer state encoding.
package ieee_fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [31:0]      POS_ZERO = 32'h0000_0000;
  localparam logic [31:0]      POS_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ieee_normalize_seq_pack.sv
// Packs sign, exponent and stored fraction into a 32-bit float word.
module ieee_normalize_seq_pack
  import ieee_fp_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  output logic [31:0]       result
);

  assign result = {sign, exp, frac};

endmodule

// File: rtl/ieee_normalize_seq.sv
// Normalise-and-pack back end of the sequential single-precision adder.
//
//  state | meaning
//  IDLE  | ready for a new raw sum
//  EVAL  | classify: special, zero, carry, normal, denormal, or needs left shift
//  SHIFT | one-bit-per-cycle left normalisation until hidden bit or exp hits 1
//  DONE  | result valid, held until out_ready
module ieee_normalize_seq
  import ieee_fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W:0]      exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [31:0]         res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic                pk_sign;
  logic [EXP_W-1:0]    pk_exp;
  logic [FRAC_W-1:0]   pk_frac;
  logic [31:0]         pk_result;
  logic [EXP_W:0]      exp_inc;

  assign exp_inc = exp_q + 9'd1;

  ieee_normalize_seq_pack u_pack (
    .sign   (pk_sign),
    .exp    (pk_exp),
    .frac   (pk_frac),
    .result (pk_result)
  );

  // Next-state, datapath and result capture.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    pk_sign = sign_q;
    pk_exp  = exp_q[EXP_W-1:0];
    pk_frac = mant_q[FRAC_W-1:0];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = EVAL;
        end
      end

      EVAL: begin
        state_d = DONE;
        if (exp_q == {1'b0, EXP_MAX}) begin
          pk_exp = EXP_MAX;
          res_d  = pk_result;
        end else if (mant_q == '0) begin
          // Exact cancellation always yields +0.
          pk_sign = 1'b0;
          pk_exp  = '0;
          pk_frac = '0;
          res_d   = pk_result;
        end else if (mant_q[MANT_W-1]) begin
          mant_d = mant_q >> 1;
          exp_d  = exp_inc;
          if (exp_inc == {1'b0, EXP_MAX}) begin
            pk_exp  = EXP_MAX;
            pk_frac = '0;
            ovf_d   = 1'b1;
          end else begin
            pk_exp  = exp_inc[EXP_W-1:0];
            pk_frac = mant_q[FRAC_W:1];
          end
          res_d = pk_result;
        end else if (mant_q[FRAC_W]) begin
          // A hidden bit with exp 0 means the denormal sum carried into normal range.
          pk_exp = (exp_q == '0) ? 8'd1 : exp_q[EXP_W-1:0];
          res_d  = pk_result;
        end else if (exp_q == '0) begin
          pk_exp = '0;
          res_d  = pk_result;
        end else begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (mant_q[FRAC_W]) begin
          res_d   = pk_result;
          state_d = DONE;
        end else if (exp_q == 9'd1) begin
          pk_exp  = '0;
          res_d   = pk_result;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 9'd1;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_ieee_normalize_seq.sv
// Directed bench for the normalise-and-pack back end.
module tb_ieee_normalize_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int checks = 0;
  int errors = 0;

  ieee_normalize_seq dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept one operation, measure latency (edges after accept until out_valid
  // is seen high before the next edge), check result/flags, then retire it.
  task automatic run_op(input string name, input vec_t v);
    int lat;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = ~v.sign;
    in_exp   = 8'hA5;
    in_mant  = 25'h1555555;
    @(negedge clk);
    chk({name, "_flags_clear"}, {30'd0, out_overflow, out_underflow}, 32'd0);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid never rose, expected latency %0d", name, v.lat);
    end else begin
      chk({name, "_lat"}, lat + 1, v.lat);
      chk({name, "_res"}, out_result, v.res);
      chk({name, "_ovf"}, {31'd0, out_overflow}, {31'd0, v.ovf});
      chk({name, "_unf"}, {31'd0, out_underflow}, {31'd0, v.unf});
      chk({name, "_busy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] held;

    vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 32'h40000000, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 8'd130, 25'h0200000, 32'h40000000, 1'b0, 1'b0, 5};
    vecs[2]  = '{1'b1, 8'd100, 25'h0000000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b0, 8'd255, 25'h0C00000, 32'h7FC00000, 1'b0, 1'b0, 2};
    vecs[4]  = '{1'b0, 8'd254, 25'h1000000, 32'h7F800000, 1'b1, 1'b0, 2};
    vecs[5]  = '{1'b1, 8'd254, 25'h1000000, 32'hFF800000, 1'b1, 1'b0, 2};
    vecs[6]  = '{1'b0, 8'd3,   25'h0000100, 32'h00000400, 1'b0, 1'b1, 5};
    vecs[7]  = '{1'b0, 8'd0,   25'h0800001, 32'h00800001, 1'b0, 1'b0, 2};
    vecs[8]  = '{1'b1, 8'd0,   25'h0400000, 32'h80400000, 1'b0, 1'b0, 2};
    vecs[9]  = '{1'b1, 8'd128, 25'h0C00000, 32'hC0400000, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b0, 8'd127, 25'h1800000, 32'h40400000, 1'b0, 1'b0, 2};
    vecs[11] = '{1'b0, 8'd100, 25'h0000001, 32'h26800000, 1'b0, 1'b0, 26};
    vecs[12] = '{1'b0, 8'd1,   25'h0400000, 32'h00400000, 1'b0, 1'b1, 3};
    vecs[13] = '{1'b1, 8'd255, 25'h1000001, 32'hFF800001, 1'b0, 1'b0, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_outputs", {29'd0, out_valid, out_overflow, out_underflow}, 32'd0);
    chk("reset_result", out_result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Hold in DONE with out_ready low; busy-time in_valid must be ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'd128;
    in_mant  = 25'h0C00000;
    @(posedge clk);
    #1;
    in_sign  = 1'b0;
    in_exp   = 8'd5;
    in_mant  = 25'h1FFFFFF;
    repeat (2) @(negedge clk);
    held = out_result;
    chk("hold_first_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_first_res", held, 32'hC0400000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold_res%0d", i), out_result, 32'hC0400000);
      chk($sformatf("hold_inrdy%0d", i), {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_inrdy", {31'd0, in_ready}, 32'd1);
    chk("hold_release_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a long left-shift sequence.
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'd100;
    in_mant  = 25'h0000001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midshift_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_outputs", {29'd0, out_valid, out_overflow, out_underflow}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = vecs[0];
    run_op("after_rst", v);
    v = vecs[6];
    run_op("after_rst_unf", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
